icache_fetch_port: RTL and testbench
====================================

Name: icache_fetch_port

Overview:
- Direct-mapped instruction cache that serves the fetch unit's instruction-bus port: bus_address, bus_en, bus_squashn, bus_readdata, bus_wait, bus_ecause.
- Sits between fetch and the system memory interconnect.
- Hits return the instruction on the cycle after the request, which matches the synchronous-RAM timing fetch expects.
- Misses raise bus_wait and refill the whole line one word at a time over a single-outstanding-read memory port.

Parameters:
- LINES, 64: number of cache lines.
- LOG2LINES, 6: log2(LINES).
- LINE_WORDS, 4: 32-bit words per line.
- LOG2LINE_WORDS, 2: log2(LINE_WORDS).
- ECAUSE_IBE, 32'h18: bus_ecause value on an instruction bus error.

Ports:
- clk  in  1  single clock; everything is posedge.
- reset  in  1  asynchronous, active-high reset.
- bus_address  in  32  fetch address; word aligned; held stable by fetch while bus_wait=1.
- bus_en  in  1  request strobe; sampled only when the FSM accepts a request.
- bus_squashn  in  1  active-low squash of the request currently in LOOKUP.
- bus_readdata  out  32  instruction; valid when bus_wait=0 in LOOKUP(hit)/DELIVER.
- bus_wait  out  1  stall to fetch.
- bus_ecause  out  32  exception cause of the last delivered request.
- flush  in  1  one-cycle pulse; invalidate the whole cache.
- mem_address  out  32  refill word address.
- mem_read  out  1  refill read request; held until accepted.
- mem_waitrequest  in  1  memory not accepting mem_read.
- mem_readdata  in  32  returned word.
- mem_readdatavalid  in  1  mem_readdata valid this cycle.
- mem_error  in  1  qualifies mem_readdatavalid; the beat returned an error.

Behaviour:
- Clocking and reset: one clock clk; reset is asynchronous and active-high. Reset values:
  - state=IDLE, all valid bits=0.
  - bus_wait=0, bus_readdata=0, bus_ecause=0.
  - mem_read=0, mem_address=0, beat=0, kill=0.
- Address split: word=addr[2+:LOG2LINE_WORDS]; idx=addr[2+LOG2LINE_WORDS+:LOG2LINES]; tag=remaining upper bits.
- IDLE: bus_wait=0. If bus_en=1: capture req_addr<=bus_address, launch the synchronous tag/data read at idx, go to LOOKUP.
- LOOKUP: hit = valid[idx] & tag match.
  - Squash (bus_squashn=0): bus_wait=0, bus_readdata don't-care, no refill, bus_ecause=0. Go to IDLE, or to LOOKUP if bus_en=1, capturing the new address.
  - Hit: bus_wait=0, bus_readdata=stored word, bus_ecause=0. If bus_en=1, accept the next request the same cycle (back-to-back hits at 1 per cycle); otherwise go to IDLE.
  - Miss: bus_wait=1 combinationally that cycle; beat<=0; go to REFILL_REQ.
- REFILL_REQ: mem_read=1, mem_address={tag,idx,beat,2'b00}, bus_wait=1. When mem_waitrequest=0, go to REFILL_WAIT.
- REFILL_WAIT: mem_read=0, bus_wait=1. On mem_readdatavalid:
  - Write the word to data[idx][beat].
  - If beat==req word, capture it into the deliver register.
  - OR mem_error into a sticky err flag.
  - Not the last beat: beat<=beat+1, go to REFILL_REQ.
  - Last beat: write the tag; set valid[idx]=~err&~kill; go to DELIVER.
- DELIVER: bus_wait=0, bus_readdata=captured word, bus_ecause=err?ECAUSE_IBE:0. Clear err and kill. Accept bus_en exactly as IDLE does.
- bus_ecause holds its value until the next delivery (a LOOKUP hit or a DELIVER).
- bus_en, bus_address and bus_squashn are ignored in REFILL_REQ and REFILL_WAIT. Fetch holds the address during refill; a squash during refill takes effect on fetch's next request.
- flush: all valid bits clear on the next edge, in any state.
  - If in REFILL_REQ or REFILL_WAIT, set kill: the refill still completes and delivers, but the line is not validated.
  - flush in LOOKUP takes effect after the current hit/miss decision.
- Bus error: a line with any errored beat is never validated, so the next access to it misses and refills again.
- reset mid-refill: return to IDLE immediately and drop mem_read. The interconnect tolerates an abandoned read; a late mem_readdatavalid in IDLE is ignored.
- No writes from fetch. Self-modifying or boot-loaded code requires flush.

Decomposition:
- Shared package:
  - FSM state encoding: IDLE, LOOKUP, REFILL_REQ, REFILL_WAIT, DELIVER.
  - ECAUSE_IBE.
  - Field-position localparams derived from the parameters.
- One sub-module, icache_store: tag and data arrays built on the team's dual-port RAM (dpram).
  - Port a: refill write.
  - Port b: lookup read.
- Valid bits stay as flops in the top module so reset and flush are single-cycle.

Test Plan:
- Cold miss: reset, bus_en with bus_address=32'h0400_0000, memory returns 32'hA0..A3 for words 0..3 with 2-cycle latency.
  - Required: 4 mem_read handshakes at 0x0400_0000, 0x0400_0004, 0x0400_0008, 0x0400_000C.
  - Required: bus_wait=1 throughout, then DELIVER with bus_readdata=32'hA0, bus_wait=0.
- Back-to-back hits: after the cold miss, bus_en on 4 consecutive cycles for 0x0400_0004..0x0400_0010.
  - Required: 0xA1, 0xA2, 0xA3 on consecutive cycles with bus_wait=0.
  - Required: 0x0400_0010 then misses (new line).
- Conflict eviction: fill 0x0400_0000, then access 0x0400_0400 (same idx, different tag) and again 0x0400_0000.
  - Required: all three accesses refill.
- Squash in LOOKUP: a miss address with bus_squashn=0 in LOOKUP.
  - Required: bus_wait=0, no mem_read, state back to IDLE.
- Flush during refill: assert flush on the second beat of a miss at 0x0400_0020.
  - Required: delivery completes; a re-access of 0x0400_0020 misses again.
- Bus error: mem_error=1 on beat 2.
  - Required: bus_ecause=32'h18 at DELIVER; the line stays invalid; bus_ecause=0 after the next clean hit.

Source files
------------

// File: rtl/icache_fetch_port_pkg.sv
// Shared definitions for the fetch-port instruction cache: FSM encoding,
// exception cause and address field helpers.
package icache_fetch_port_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    REFILL_REQ,
    REFILL_WAIT,
    DELIVER
  } state_t;

  localparam int ADDR_W   = 32;
  localparam int WORD_W   = 32;
  localparam int WORD_LSB = 2;

  localparam logic [31:0] ECAUSE_IBE = 32'h18;

  function automatic int idx_lsb(input int log2line_words);
    return WORD_LSB + log2line_words;
  endfunction

  function automatic int tag_lsb(input int log2line_words, input int log2lines);
    return WORD_LSB + log2line_words + log2lines;
  endfunction

endpackage

// File: rtl/icache_fetch_port_if.sv
// Fetch-side instruction bus plus the refill memory port of the cache.
interface icache_fetch_port_if;
  import icache_fetch_port_pkg::*;

  logic [ADDR_W-1:0] bus_address;
  logic              bus_en;
  logic              bus_squashn;
  logic [WORD_W-1:0] bus_readdata;
  logic              bus_wait;
  logic [31:0]       bus_ecause;
  logic              flush;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_read;
  logic              mem_waitrequest;
  logic [WORD_W-1:0] mem_readdata;
  logic              mem_readdatavalid;
  logic              mem_error;

  // Environment side: fetch unit and memory interconnect
  modport master (
    output bus_address, bus_en, bus_squashn, flush,
           mem_waitrequest, mem_readdata, mem_readdatavalid, mem_error,
    input  bus_readdata, bus_wait, bus_ecause, mem_address, mem_read
  );

  modport slave (
    input  bus_address, bus_en, bus_squashn, flush,
           mem_waitrequest, mem_readdata, mem_readdatavalid, mem_error,
    output bus_readdata, bus_wait, bus_ecause, mem_address, mem_read
  );

endinterface

// File: rtl/icache_fetch_port_store.sv
// Tag and data arrays of the cache: port a takes refill writes, port b
// serves the synchronous lookup read.
module dpram #(
  parameter int AW = 6,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          we_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] wdata_a,
  input  logic          re_b,
  input  logic [AW-1:0] addr_b,
  output logic [DW-1:0] rdata_b
);
  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= wdata_a;
    if (re_b) rdata_b <= mem[addr_b];
  end
endmodule

module icache_store
  import icache_fetch_port_pkg::*;
#(
  parameter int LOG2LINES      = 6,
  parameter int LOG2LINE_WORDS = 2,
  parameter int TAG_W          = 24
) (
  input  logic                      clk,
  input  logic                      wr_en,
  input  logic                      tag_wr,
  input  logic [LOG2LINES-1:0]      wr_idx,
  input  logic [LOG2LINE_WORDS-1:0] wr_word,
  input  logic [WORD_W-1:0]         wr_data,
  input  logic [TAG_W-1:0]          wr_tag,
  input  logic                      rd_en,
  input  logic [LOG2LINES-1:0]      rd_idx,
  input  logic [LOG2LINE_WORDS-1:0] rd_word,
  output logic [WORD_W-1:0]         rd_data,
  output logic [TAG_W-1:0]          rd_tag
);

  dpram #(.AW(LOG2LINES), .DW(TAG_W)) tag_ram (
    .clk    (clk),
    .we_a   (tag_wr),
    .addr_a (wr_idx),
    .wdata_a(wr_tag),
    .re_b   (rd_en),
    .addr_b (rd_idx),
    .rdata_b(rd_tag)
  );

  dpram #(.AW(LOG2LINES + LOG2LINE_WORDS), .DW(WORD_W)) data_ram (
    .clk    (clk),
    .we_a   (wr_en),
    .addr_a ({wr_idx, wr_word}),
    .wdata_a(wr_data),
    .re_b   (rd_en),
    .addr_b ({rd_idx, rd_word}),
    .rdata_b(rd_data)
  );

endmodule

// File: rtl/icache_fetch_port.sv
// Direct-mapped instruction cache on the fetch bus: one-cycle hits, line
// refill one word at a time over a single-outstanding-read memory port.
module icache_fetch_port #(
  parameter int          LINES          = 64,
  parameter int          LOG2LINES      = 6,
  parameter int          LINE_WORDS     = 4,
  parameter int          LOG2LINE_WORDS = 2,
  parameter logic [31:0] ECAUSE_IBE     = icache_fetch_port_pkg::ECAUSE_IBE
) (
  input logic                clk,
  input logic                reset,
  icache_fetch_port_if.slave bus
);
  import icache_fetch_port_pkg::*;

  localparam int IDX_LSB = idx_lsb(LOG2LINE_WORDS);
  localparam int TAG_LSB = tag_lsb(LOG2LINE_WORDS, LOG2LINES);
  localparam int TAG_W   = ADDR_W - TAG_LSB;

  state_t                    state, state_nx;
  logic [LINES-1:0]          valid;
  logic [ADDR_W-1:WORD_LSB]  req_addr;
  logic [LOG2LINE_WORDS-1:0] beat;
  logic                      err, kill;
  logic [WORD_W-1:0]         dlv_word, rd_data;
  logic [31:0]               ecause_q, ecause_now;
  logic [TAG_W-1:0]          rd_tag;
  logic                      hit, accept, deliver_evt, wait_c, refill_beat, last_beat;

  wire [LOG2LINE_WORDS-1:0] req_word = req_addr[WORD_LSB +: LOG2LINE_WORDS];
  wire [LOG2LINES-1:0]      req_idx  = req_addr[IDX_LSB +: LOG2LINES];
  wire [TAG_W-1:0]          req_tag  = req_addr[ADDR_W-1:TAG_LSB];

  assign hit         = valid[req_idx] && (rd_tag == req_tag);
  assign refill_beat = (state == REFILL_WAIT) && bus.mem_readdatavalid;
  assign last_beat   = (beat == LOG2LINE_WORDS'(LINE_WORDS - 1));

  icache_store #(
    .LOG2LINES     (LOG2LINES),
    .LOG2LINE_WORDS(LOG2LINE_WORDS),
    .TAG_W         (TAG_W)
  ) u_store (
    .clk    (clk),
    .wr_en  (refill_beat),
    .tag_wr (refill_beat && last_beat),
    .wr_idx (req_idx),
    .wr_word(beat),
    .wr_data(bus.mem_readdata),
    .wr_tag (req_tag),
    .rd_en  (accept),
    .rd_idx (bus.bus_address[IDX_LSB +: LOG2LINES]),
    .rd_word(bus.bus_address[WORD_LSB +: LOG2LINE_WORDS]),
    .rd_data(rd_data),
    .rd_tag (rd_tag)
  );

  // A squash or a hit both complete the request and may accept the next one
  always_comb begin
    state_nx    = state;
    accept      = 1'b0;
    wait_c      = 1'b0;
    deliver_evt = 1'b0;
    ecause_now  = ecause_q;
    case (state)
      IDLE: begin
        accept = bus.bus_en;
        if (bus.bus_en) state_nx = LOOKUP;
      end
      LOOKUP: begin
        if (!bus.bus_squashn || hit) begin
          ecause_now  = '0;
          deliver_evt = 1'b1;
          accept      = bus.bus_en;
          state_nx    = bus.bus_en ? LOOKUP : IDLE;
        end else begin
          wait_c   = 1'b1;
          state_nx = REFILL_REQ;
        end
      end
      REFILL_REQ: begin
        wait_c = 1'b1;
        if (!bus.mem_waitrequest) state_nx = REFILL_WAIT;
      end
      REFILL_WAIT: begin
        wait_c = 1'b1;
        if (bus.mem_readdatavalid) state_nx = last_beat ? DELIVER : REFILL_REQ;
      end
      DELIVER: begin
        ecause_now  = err ? ECAUSE_IBE : '0;
        deliver_evt = 1'b1;
        accept      = bus.bus_en;
        state_nx    = bus.bus_en ? LOOKUP : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      valid    <= '0;
      beat     <= '0;
      err      <= 1'b0;
      kill     <= 1'b0;
      ecause_q <= '0;
      dlv_word <= '0;
    end else begin
      state <= state_nx;
      if (deliver_evt) ecause_q <= ecause_now;
      if (state == LOOKUP && state_nx == REFILL_REQ) beat <= '0;
      if (refill_beat) begin
        err <= err | bus.mem_error;
        if (!last_beat) beat <= beat + LOG2LINE_WORDS'(1);
        if (beat == req_word) dlv_word <= bus.mem_readdata;
      end
      if (state == DELIVER) begin
        err  <= 1'b0;
        kill <= 1'b0;
      end
      // Flush wins over validating a line that completes on the same edge
      if (bus.flush) begin
        valid <= '0;
        if (state == REFILL_REQ || state == REFILL_WAIT) kill <= 1'b1;
      end else if (refill_beat && last_beat) begin
        valid[req_idx] <= ~(err | bus.mem_error) & ~kill;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) req_addr <= bus.bus_address[ADDR_W-1:WORD_LSB];
  end

  assign bus.bus_wait     = wait_c;
  assign bus.bus_ecause   = ecause_now;
  assign bus.bus_readdata = (state == LOOKUP) ? rd_data : dlv_word;
  assign bus.mem_read     = (state == REFILL_REQ);
  assign bus.mem_address  = (state == REFILL_REQ) ? {req_addr[ADDR_W-1:IDX_LSB], beat, 2'b00} : '0;

endmodule

// File: tb/tb_icache_fetch_port.sv
// Directed plus randomized bench for icache_fetch_port with a memory responder
// and an address-level cache occupancy model.
module tb_icache_fetch_port;
  import icache_fetch_port_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  icache_fetch_port_if bus_if ();

  icache_fetch_port dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  int          tests = 0;
  int          fails = 0;
  logic [31:0] err_addr = '1;
  bit          rand_mem = 1'b0;
  int          lat_cnt = 0;
  logic [31:0] pend_addr = '0;
  logic [31:0] hs_q[$];
  bit          model_valid[64];
  logic [21:0] model_tag[64];
  logic [31:0] exp_ecause = '0;
  bit          refilled;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA0 + ((a >> 2) - 32'h0100_0000);
  endfunction

  function automatic logic [31:0] rnd();
    return 32'h0400_0000 | (32'($urandom_range(0, 3)) << 10)
         | (32'($urandom_range(0, 7)) << 4) | (32'($urandom_range(0, 3)) << 2);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_flush();
    foreach (model_valid[i]) model_valid[i] = 1'b0;
  endtask

  // Memory: accepts one read at a time, answers after a latency
  initial begin
    bus_if.mem_waitrequest   = 1'b1;
    bus_if.mem_readdata      = '0;
    bus_if.mem_readdatavalid = 1'b0;
    bus_if.mem_error         = 1'b0;
    forever begin
      @(negedge clk);
      bus_if.mem_readdatavalid = 1'b0;
      bus_if.mem_error         = 1'b0;
      bus_if.mem_readdata      = '0;
      if (lat_cnt > 0) begin
        lat_cnt--;
        if (lat_cnt == 0) begin
          bus_if.mem_readdatavalid = 1'b1;
          bus_if.mem_readdata      = mem_word(pend_addr);
          bus_if.mem_error         = (pend_addr == err_addr);
        end
      end
      bus_if.mem_waitrequest = 1'b1;
      if (bus_if.mem_read && lat_cnt == 0) begin
        if (!rand_mem || $urandom_range(0, 1) == 0) begin
          bus_if.mem_waitrequest = 1'b0;
          hs_q.push_back(bus_if.mem_address);
          pend_addr = bus_if.mem_address;
          lat_cnt   = rand_mem ? int'($urandom_range(1, 3)) : 2;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic start(input logic [31:0] a);
    @(negedge clk);
    bus_if.bus_en      = 1'b1;
    bus_if.bus_address = a;
    bus_if.bus_squashn = 1'b1;
  endtask

  // Called right after start (or a chained request); resolves the LOOKUP of a
  task automatic finish(input logic [31:0] a, input bit squash, input bit has_next,
                        input logic [31:0] nxt, input int fb);
    int          idx, n;
    logic [21:0] tg;
    bit          hit, line_err, flushed;
    idx = int'((a >> 4) & 32'h3F);
    tg  = a[31:10];
    hit = model_valid[idx] && (model_tag[idx] == tg);
    @(negedge clk);
    hs_q.delete();
    bus_if.bus_squashn = !squash;
    if (squash || hit) begin
      bus_if.bus_en = has_next;
      if (has_next) bus_if.bus_address = nxt;
      #1;
      refilled = 1'b0;
      check(squash ? "squash_wait" : "hit_wait", 32'(bus_if.bus_wait), 0);
      if (!squash) check("hit_data", bus_if.bus_readdata, mem_word(a));
      check("lookup_ecause", bus_if.bus_ecause, 0);
      exp_ecause = '0;
      if (squash && !has_next) begin
        @(negedge clk); #1;
        check("squash_no_read", 32'(bus_if.mem_read), 0);
        check("squash_no_beats", 32'(hs_q.size()), 0);
      end
    end else begin
      bus_if.bus_en = 1'b0;
      #1;
      refilled = 1'b1;
      check("miss_wait", 32'(bus_if.bus_wait), 1);
      check("miss_ecause_hold", bus_if.bus_ecause, exp_ecause);
      line_err = ((err_addr >> 4) == (a >> 4));
      flushed  = 1'b0;
      n        = 0;
      do begin
        @(negedge clk);
        bus_if.flush = 1'b0;
        #1;
        n++;
        if (fb >= 0 && !flushed && bus_if.bus_wait && hs_q.size() == fb + 1) begin
          bus_if.flush = 1'b1;
          flushed      = 1'b1;
        end
      end while (bus_if.bus_wait && n < 300);
      check("refill_done", 32'(bus_if.bus_wait), 0);
      check("deliver_data", bus_if.bus_readdata, mem_word(a));
      check("deliver_ecause", bus_if.bus_ecause, line_err ? ECAUSE_IBE : 32'h0);
      check("refill_beats", 32'(hs_q.size()), 4);
      for (int i = 0; i < hs_q.size() && i < 4; i++)
        check("beat_addr", hs_q[i], (a & 32'hFFFF_FFF0) + 32'(4 * i));
      bus_if.bus_en = has_next;
      if (has_next) begin
        bus_if.bus_address = nxt;
        bus_if.bus_squashn = 1'b1;
      end
      if (flushed) model_flush();
      model_tag[idx]   = tg;
      model_valid[idx] = !line_err && !flushed;
      exp_ecause       = line_err ? ECAUSE_IBE : 32'h0;
    end
  endtask

  initial begin
    logic [31:0] cur, nxt;
    bit          chain, sq;
    int          fb;
    reset                = 1'b1;
    bus_if.bus_en        = 1'b0;
    bus_if.bus_address   = '0;
    bus_if.bus_squashn   = 1'b1;
    bus_if.flush         = 1'b0;
    model_flush();
    repeat (2) @(negedge clk);
    #1;
    check("rst_wait", 32'(bus_if.bus_wait), 0);
    check("rst_readdata", bus_if.bus_readdata, 0);
    check("rst_ecause", bus_if.bus_ecause, 0);
    check("rst_mem_read", 32'(bus_if.mem_read), 0);
    check("rst_mem_address", bus_if.mem_address, 0);
    @(negedge clk);
    reset = 1'b0;

    // Cold miss
    start(32'h0400_0000);
    finish(32'h0400_0000, 0, 0, '0, -1);
    check("cold_refilled", 32'(refilled), 1);

    // Back-to-back hits, then a new line
    start(32'h0400_0004);
    finish(32'h0400_0004, 0, 1, 32'h0400_0008, -1);
    check("b2b_hit1", 32'(refilled), 0);
    finish(32'h0400_0008, 0, 1, 32'h0400_000C, -1);
    check("b2b_hit2", 32'(refilled), 0);
    finish(32'h0400_000C, 0, 1, 32'h0400_0010, -1);
    check("b2b_hit3", 32'(refilled), 0);
    finish(32'h0400_0010, 0, 0, '0, -1);
    check("b2b_newline", 32'(refilled), 1);

    // Conflict eviction
    start(32'h0400_0400);
    finish(32'h0400_0400, 0, 0, '0, -1);
    check("conflict_1", 32'(refilled), 1);
    start(32'h0400_0000);
    finish(32'h0400_0000, 0, 0, '0, -1);
    check("conflict_2", 32'(refilled), 1);

    // Squash in LOOKUP, alone and chained into a hit
    start(32'h0400_0080);
    finish(32'h0400_0080, 1, 0, '0, -1);
    start(32'h0400_0084);
    finish(32'h0400_0084, 1, 1, 32'h0400_0004, -1);
    finish(32'h0400_0004, 0, 0, '0, -1);
    check("after_squash_hit", 32'(refilled), 0);

    // Flush on the second beat of a refill
    start(32'h0400_0020);
    finish(32'h0400_0020, 0, 0, '0, 1);
    start(32'h0400_0020);
    finish(32'h0400_0020, 0, 0, '0, -1);
    check("flush_remiss", 32'(refilled), 1);

    // Bus error on beat 2
    err_addr = 32'h0400_0048;
    start(32'h0400_0040);
    finish(32'h0400_0040, 0, 0, '0, -1);
    @(negedge clk); #1;
    check("err_ecause_hold", bus_if.bus_ecause, ECAUSE_IBE);
    err_addr = '1;
    start(32'h0400_0020);
    finish(32'h0400_0020, 0, 0, '0, -1);
    check("clean_hit", 32'(refilled), 0);
    start(32'h0400_0040);
    finish(32'h0400_0040, 0, 0, '0, -1);
    check("err_line_invalid", 32'(refilled), 1);

    // Randomized traffic
    rand_mem = 1'b1;
    cur = rnd();
    start(cur);
    for (int i = 0; i < 150; i++) begin
      nxt      = rnd();
      chain    = ($urandom_range(0, 1) == 1);
      sq       = ($urandom_range(0, 9) == 0);
      fb       = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
      err_addr = ($urandom_range(0, 7) == 0) ? rnd() : '1;
      finish(cur, sq, chain, nxt, fb);
      if (!chain) begin
        if ($urandom_range(0, 15) == 0) begin
          @(negedge clk); bus_if.flush = 1'b1;
          @(negedge clk); bus_if.flush = 1'b0;
          model_flush();
        end
        start(nxt);
      end
      cur = nxt;
    end
    err_addr = '1;
    finish(cur, 0, 0, '0, -1);

    // Reset in the middle of a refill
    rand_mem = 1'b0;
    repeat (4) @(negedge clk);
    start(32'h0400_0300);
    @(negedge clk); #1;
    bus_if.bus_en = 1'b0;
    check("rst_mid_miss", 32'(bus_if.bus_wait), 1);
    @(negedge clk); #1;
    check("rst_mid_read_before", 32'(bus_if.mem_read), 1);
    reset = 1'b1;
    #1;
    check("rst_mid_read", 32'(bus_if.mem_read), 0);
    check("rst_mid_wait", 32'(bus_if.bus_wait), 0);
    check("rst_mid_ecause", bus_if.bus_ecause, 0);
    @(negedge clk);
    reset = 1'b0;
    model_flush();
    exp_ecause = '0;
    start(32'h0400_0000);
    finish(32'h0400_0000, 0, 0, '0, -1);
    check("post_reset_refill", 32'(refilled), 1);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
